// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and the winner-select helper for the two-port SRAM arbiter.
package sram_port_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_P0   = 2'b01;
  localparam logic [1:0] GRANT_P1   = 2'b10;

  // Returns 1 when port 1 should win; rrPtr names the port favoured on a tie.
  function automatic logic pickWinner(input logic p0Req, input logic p1Req,
                                      input logic rrPtr, input logic fixedPrio);
    if (fixedPrio)
      return !p0Req;
    if (p0Req && p1Req)
      return rrPtr;
    return !p0Req;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and controller-side bundles for the SRAM port arbiter.
interface sram_port_arbiter_if #(
  parameter int ADDRESS_LEN  = 32,
  parameter int REGISTER_LEN = 32
);
  logic                    read_enable;
  logic                    write_enable;
  logic [ADDRESS_LEN-1:0]  address;
  logic [REGISTER_LEN-1:0] write_data;
  logic [REGISTER_LEN-1:0] read_data;
  logic                    ready;

  modport master (output read_enable, write_enable, address, write_data,
                  input  read_data, ready);
  modport slave  (input  read_enable, write_enable, address, write_data,
                  output read_data, ready);
endinterface

interface sram_mem_if #(
  parameter int ADDRESS_LEN  = 32,
  parameter int REGISTER_LEN = 32
);
  logic                    read_enable;
  logic                    write_enable;
  logic [ADDRESS_LEN-1:0]  address;
  logic [REGISTER_LEN-1:0] write_data;
  logic [REGISTER_LEN-1:0] read_data;
  logic                    ready;

  modport master (output read_enable, write_enable, address, write_data,
                  input  read_data, ready);
  modport slave  (input  read_enable, write_enable, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM controller port between a MEM-stage requester (p0) and a
// secondary master (p1); the winning request is latched for the whole transaction.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDRESS_LEN  = 32,
  parameter int REGISTER_LEN = 32,
  parameter bit FIXED_PRIO   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  sram_port_arbiter_if.slave p0,
  sram_port_arbiter_if.slave p1,
  sram_mem_if.master         mem,
  output logic [1:0]         grant
);

  arb_state_e              r_state;
  logic                    r_rrPtr;
  logic [1:0]              r_grant;
  logic                    r_memRe;
  logic                    r_memWe;
  logic [ADDRESS_LEN-1:0]  r_memAddr;
  logic [REGISTER_LEN-1:0] r_memWd;

  logic w_p0Req;
  logic w_p1Req;
  logic w_winner;
  logic w_done;

  assign w_p0Req  = p0.read_enable | p0.write_enable;
  assign w_p1Req  = p1.read_enable | p1.write_enable;
  assign w_winner = pickWinner(w_p0Req, w_p1Req, r_rrPtr, FIXED_PRIO);
  assign w_done   = (r_state == ARB_BUSY) & mem.ready;

  // A read wins over a write when a requester raises both enables.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_rrPtr   <= 1'b0;
      r_grant   <= GRANT_NONE;
      r_memRe   <= 1'b0;
      r_memWe   <= 1'b0;
      r_memAddr <= '0;
      r_memWd   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_p0Req | w_p1Req) begin
            r_state <= ARB_BUSY;
            r_rrPtr <= ~w_winner;
            if (w_winner) begin
              r_grant   <= GRANT_P1;
              r_memRe   <= p1.read_enable;
              r_memWe   <= p1.write_enable & ~p1.read_enable;
              r_memAddr <= p1.address;
              r_memWd   <= p1.write_data;
            end else begin
              r_grant   <= GRANT_P0;
              r_memRe   <= p0.read_enable;
              r_memWe   <= p0.write_enable & ~p0.read_enable;
              r_memAddr <= p0.address;
              r_memWd   <= p0.write_data;
            end
          end
        end
        ARB_BUSY: begin
          if (mem.ready) begin
            r_state <= ARB_IDLE;
            r_grant <= GRANT_NONE;
            r_memRe <= 1'b0;
            r_memWe <= 1'b0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign mem.read_enable  = r_memRe;
  assign mem.write_enable = r_memWe;
  assign mem.address      = r_memAddr;
  assign mem.write_data   = r_memWd;
  assign grant            = r_grant;

  // Requesters stay frozen until their own transaction completes.
  assign p0.ready     = rst | ~w_p0Req | (w_done & r_grant[0]);
  assign p1.ready     = rst | ~w_p1Req | (w_done & r_grant[1]);
  assign p0.read_data = mem.read_data;
  assign p1.read_data = mem.read_data;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a round-robin instance driven by a
// vector table and hand sequences, plus a fixed-priority twin on the same inputs.
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_arbiter_if #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) p0If ();
  sram_port_arbiter_if #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) p1If ();
  sram_mem_if          #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) memIf ();
  sram_port_arbiter_if #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) fpP0If ();
  sram_port_arbiter_if #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) fpP1If ();
  sram_mem_if          #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW)) fpMemIf ();
  logic [1:0] grant;
  logic [1:0] fpGrant;

  sram_port_arbiter #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .p0(p0If), .p1(p1If), .mem(memIf), .grant(grant));

  sram_port_arbiter #(.ADDRESS_LEN(AW), .REGISTER_LEN(DW), .FIXED_PRIO(1'b1)) dutFixed (
    .clk(clk), .rst(rst), .p0(fpP0If), .p1(fpP1If), .mem(fpMemIf), .grant(fpGrant));

  assign fpP0If.read_enable  = p0If.read_enable;
  assign fpP0If.write_enable = p0If.write_enable;
  assign fpP0If.address      = p0If.address;
  assign fpP0If.write_data   = p0If.write_data;
  assign fpP1If.read_enable  = p1If.read_enable;
  assign fpP1If.write_enable = p1If.write_enable;
  assign fpP1If.address      = p1If.address;
  assign fpP1If.write_data   = p1If.write_data;

  // Controller model: accepts with ready=0, then 7 busy cycles, ready=1 on the last.
  logic [DW-1:0] memArray [0:1023];
  logic          ctrlBusy;
  logic [2:0]    ctrlCnt;
  assign memIf.read_data = memArray[memIf.address[11:2]];

  always @(posedge clk) begin
    if (rst) begin
      ctrlBusy      <= 1'b0;
      ctrlCnt       <= 3'd0;
      memIf.ready   <= 1'b0;
      memArray[256] <= 32'h1234_5678;
      memArray[258] <= 32'h0BAD_F00D;
    end else if (!ctrlBusy) begin
      memIf.ready <= 1'b0;
      if (memIf.read_enable | memIf.write_enable) begin
        ctrlBusy <= 1'b1;
        ctrlCnt  <= 3'd1;
      end
    end else if (memIf.ready) begin
      memIf.ready <= 1'b0;
      ctrlBusy    <= 1'b0;
      if (memIf.write_enable)
        memArray[memIf.address[11:2]] <= memIf.write_data;
    end else begin
      ctrlCnt <= ctrlCnt + 3'd1;
      if (ctrlCnt == 3'd6)
        memIf.ready <= 1'b1;
    end
  end

  logic       fpBusy;
  logic [2:0] fpCnt;
  assign fpMemIf.read_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      fpBusy        <= 1'b0;
      fpCnt         <= 3'd0;
      fpMemIf.ready <= 1'b0;
    end else if (!fpBusy) begin
      fpMemIf.ready <= 1'b0;
      if (fpMemIf.read_enable | fpMemIf.write_enable) begin
        fpBusy <= 1'b1;
        fpCnt  <= 3'd1;
      end
    end else if (fpMemIf.ready) begin
      fpMemIf.ready <= 1'b0;
      fpBusy        <= 1'b0;
    end else begin
      fpCnt <= fpCnt + 3'd1;
      if (fpCnt == 3'd6)
        fpMemIf.ready <= 1'b1;
    end
  end

  typedef struct {
    logic        rstIn;
    logic        p0Re, p0We;
    logic [31:0] p0Addr, p0Wd;
    logic        p1Re, p1We;
    logic [31:0] p1Addr, p1Wd;
    logic        eP0Rdy, eP1Rdy;
    logic        chkMem;
    logic [1:0]  eGrant;
    logic        eMemRe, eMemWe;
    logic [31:0] eMemAddr, eMemWd;
    logic [1:0]  chkRd;
    logic [31:0] eRd;
  } vec_t;

  vec_t vecs[$];
  int   vecCount  = 0;
  int   missCount = 0;

  function automatic vec_t mk(
      input logic rstIn,
      input logic p0Re, input logic p0We, input logic [31:0] p0Addr, input logic [31:0] p0Wd,
      input logic p1Re, input logic p1We, input logic [31:0] p1Addr, input logic [31:0] p1Wd,
      input logic eP0Rdy, input logic eP1Rdy,
      input logic chkMem, input logic [1:0] eGrant, input logic eMemRe, input logic eMemWe,
      input logic [31:0] eMemAddr, input logic [31:0] eMemWd,
      input logic [1:0] chkRd, input logic [31:0] eRd);
    vec_t v;
    v.rstIn = rstIn;
    v.p0Re = p0Re; v.p0We = p0We; v.p0Addr = p0Addr; v.p0Wd = p0Wd;
    v.p1Re = p1Re; v.p1We = p1We; v.p1Addr = p1Addr; v.p1Wd = p1Wd;
    v.eP0Rdy = eP0Rdy; v.eP1Rdy = eP1Rdy;
    v.chkMem = chkMem; v.eGrant = eGrant; v.eMemRe = eMemRe; v.eMemWe = eMemWe;
    v.eMemAddr = eMemAddr; v.eMemWd = eMemWd;
    v.chkRd = chkRd; v.eRd = eRd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst               = v.rstIn;
    p0If.read_enable  = v.p0Re;
    p0If.write_enable = v.p0We;
    p0If.address      = v.p0Addr;
    p0If.write_data   = v.p0Wd;
    p1If.read_enable  = v.p1Re;
    p1If.write_enable = v.p1We;
    p1If.address      = v.p1Addr;
    p1If.write_data   = v.p1Wd;
  endtask

  task automatic setIdle();
    applyStimulus(mk(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 0, 0, 0, 2'd0, 0));
  endtask

  task automatic resetDut();
    setIdle();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  // Counts cycles from now until the chosen port sees ready, watching the latched bus.
  task automatic waitReady(input bit port, input logic [31:0] expAddr, output int n,
                           output logic [31:0] rd, output bit weSeen, output bit addrHeld);
    n = 0;
    rd = 'x;
    weSeen = 1'b0;
    addrHeld = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (memIf.write_enable === 1'b1)
        weSeen = 1'b1;
      if (grant != 2'b00 && memIf.address !== expAddr)
        addrHeld = 1'b0;
      if ((port ? p1If.ready : p0If.ready) === 1'b1) begin
        rd = port ? p1If.read_data : p0If.read_data;
        return;
      end
      @(posedge clk);
      #1;
      n++;
    end
    n = -1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    logic [31:0] rd;
    bit          weSeen;
    bit          addrHeld;
    logic [1:0]  grantSeq[$];
    logic [1:0]  prevGrant;
    logic [1:0]  prevFpGrant;
    int          fpP0Grants;
    int          fpP1Grants;

    // Reset, lone p0 read, then a write/read conflict resolved round-robin.
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,1, 0,2'b00,0,0,0,0, 2'd0,0));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,1, 1,2'b00,0,0,0,0, 2'd0,0));
    vecs.push_back(mk(0, 1,0,32'h400,0, 0,0,0,0, 0,1, 1,2'b00,0,0,0,0, 2'd0,0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 1,0,32'h400,0, 0,0,0,0, 0,1, 1,2'b01,1,0,32'h400,0, 2'd0,0));
    vecs.push_back(mk(0, 1,0,32'h400,0, 0,0,0,0, 1,1, 1,2'b01,1,0,32'h400,0, 2'd1,32'h1234_5678));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,1, 1,2'b00,0,0,32'h400,0, 2'd0,0));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,1, 0,2'b00,0,0,0,0, 2'd0,0));
    vecs.push_back(mk(1, 0,0,0,0, 0,0,0,0, 1,1, 1,2'b00,0,0,0,0, 2'd0,0));
    vecs.push_back(mk(0, 0,1,32'h404,32'hDEAD_BEEF, 1,0,32'h404,0, 0,0, 1,2'b00,0,0,0,0, 2'd0,0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 0,1,32'h404,32'hDEAD_BEEF, 1,0,32'h404,0, 0,0,
                        1,2'b01,0,1,32'h404,32'hDEAD_BEEF, 2'd0,0));
    vecs.push_back(mk(0, 0,1,32'h404,32'hDEAD_BEEF, 1,0,32'h404,0, 1,0,
                      1,2'b01,0,1,32'h404,32'hDEAD_BEEF, 2'd0,0));
    vecs.push_back(mk(0, 0,0,0,0, 1,0,32'h404,0, 1,0, 1,2'b00,0,0,32'h404,32'hDEAD_BEEF, 2'd0,0));
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(0, 0,0,0,0, 1,0,32'h404,0, 1,0, 1,2'b10,1,0,32'h404,0, 2'd0,0));
    vecs.push_back(mk(0, 0,0,0,0, 1,0,32'h404,0, 1,1, 1,2'b10,1,0,32'h404,0, 2'd2,32'hDEAD_BEEF));
    vecs.push_back(mk(0, 0,0,0,0, 0,0,0,0, 1,1, 1,2'b00,0,0,32'h404,0, 2'd0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("v%0d p0Ready", i), {31'b0, p0If.ready}, {31'b0, vecs[i].eP0Rdy});
      checkOutput($sformatf("v%0d p1Ready", i), {31'b0, p1If.ready}, {31'b0, vecs[i].eP1Rdy});
      if (vecs[i].chkMem) begin
        checkOutput($sformatf("v%0d grant", i), {30'b0, grant}, {30'b0, vecs[i].eGrant});
        checkOutput($sformatf("v%0d memRe", i), {31'b0, memIf.read_enable}, {31'b0, vecs[i].eMemRe});
        checkOutput($sformatf("v%0d memWe", i), {31'b0, memIf.write_enable}, {31'b0, vecs[i].eMemWe});
        checkOutput($sformatf("v%0d memAddr", i), memIf.address, vecs[i].eMemAddr);
        checkOutput($sformatf("v%0d memWd", i), memIf.write_data, vecs[i].eMemWd);
      end
      if (vecs[i].chkRd == 2'd1)
        checkOutput($sformatf("v%0d p0ReadData", i), p0If.read_data, vecs[i].eRd);
      if (vecs[i].chkRd == 2'd2)
        checkOutput($sformatf("v%0d p1ReadData", i), p1If.read_data, vecs[i].eRd);
      @(posedge clk);
      #1;
    end

    // Continuous requests from both ports: alternation here, starvation of p1 in the fixed twin.
    resetDut();
    p0If.read_enable = 1'b1;
    p0If.address     = 32'h400;
    p1If.read_enable = 1'b1;
    p1If.address     = 32'h404;
    prevGrant   = 2'b00;
    prevFpGrant = 2'b00;
    fpP0Grants  = 0;
    fpP1Grants  = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (grant != 2'b00 && prevGrant == 2'b00)
        grantSeq.push_back(grant);
      if (fpGrant != 2'b00 && prevFpGrant == 2'b00) begin
        if (fpGrant == 2'b01) fpP0Grants++;
        if (fpGrant == 2'b10) fpP1Grants++;
      end
      prevGrant   = grant;
      prevFpGrant = fpGrant;
      @(posedge clk);
      #1;
    end
    checkOutput("rr grant count", grantSeq.size(), 32'd5);
    for (int i = 0; i < 4; i++) begin
      if (i < grantSeq.size())
        checkOutput($sformatf("rr grant %0d", i), {30'b0, grantSeq[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
      else
        checkOutput($sformatf("rr grant %0d", i), 32'hFFFF_FFFF, (i % 2 == 0) ? 32'd1 : 32'd2);
    end
    checkOutput("fixed p0 grants", fpP0Grants, 32'd5);
    checkOutput("fixed p1 grants", fpP1Grants, 32'd0);

    // p1 moves its address mid-transaction; the latched address must be used.
    resetDut();
    p1If.read_enable = 1'b1;
    p1If.address     = 32'h400;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    p1If.address = 32'h404;
    waitReady(1'b1, 32'h400, n, rd, weSeen, addrHeld);
    checkOutput("latch addrHeld", {31'b0, addrHeld}, 32'd1);
    checkOutput("latch latency", n, 32'd5);
    checkOutput("latch readData", rd, 32'h1234_5678);
    @(posedge clk);
    #1;
    setIdle();

    // Reset in the third busy cycle aborts; the still-held request restarts from scratch.
    resetDut();
    p0If.read_enable = 1'b1;
    p0If.address     = 32'h400;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst p0Ready", {31'b0, p0If.ready}, 32'd1);
    checkOutput("rst p1Ready", {31'b0, p1If.ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst memRe", {31'b0, memIf.read_enable}, 32'd0);
    checkOutput("rst grant", {30'b0, grant}, 32'd0);
    checkOutput("rst pending p0Ready", {31'b0, p0If.ready}, 32'd0);
    @(posedge clk);
    #1;
    waitReady(1'b0, 32'h400, n, rd, weSeen, addrHeld);
    checkOutput("rst retry latency", n, 32'd7);
    checkOutput("rst retry readData", rd, 32'h1234_5678);
    @(posedge clk);
    #1;
    setIdle();

    // Both enables on p0: treated as a read, memory left untouched.
    resetDut();
    p0If.read_enable  = 1'b1;
    p0If.write_enable = 1'b1;
    p0If.address      = 32'h408;
    p0If.write_data   = 32'hCAFE_F00D;
    waitReady(1'b0, 32'h408, n, rd, weSeen, addrHeld);
    checkOutput("rw latency", n, 32'd8);
    checkOutput("rw memWe seen", {31'b0, weSeen}, 32'd0);
    checkOutput("rw readData", rd, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    setIdle();
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checkOutput("rw mem unchanged", memArray[258], 32'h0BAD_F00D);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
